// File: rtl/zap_wb_slave_mem_pkg.sv
// Shared definitions for the Wishbone slave memory: FSM state encoding,
// byte-lane constants and the lane write-enable helper.
package zap_wb_slave_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } zap_wb_state_e;

  localparam logic [3:0] WB_SEL_ALL = 4'b1111;

  // Byte lanes to write for a response: none for reads, the selected ones for writes.
  function automatic logic [3:0] zap_lane_we(input logic we, input logic [3:0] sel);
    return we ? (sel & WB_SEL_ALL) : 4'b0000;
  endfunction

endpackage

// File: rtl/zap_ram_simple.sv
// Single-port word RAM with per-byte write enables and a registered,
// read-first output. Contents are deliberately not reset.
module zap_ram_simple #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/zap_wb_slave_mem.sv
// Wishbone classic single-beat slave memory with programmable wait states.
// Define ZAP_WB_SLAVE_ERR_EN to answer out-of-range addresses with o_wb_err.
module zap_wb_slave_mem
  import zap_wb_slave_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_wen,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic        o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  zap_wb_state_e state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic          wen_q;
  logic [3:0]    sel_q;
  logic [31:0]   wdat_q;
  logic          ack_q, ack_d;
  logic          accept;
  logic          ramEn;
  logic [3:0]    ramWe;
  logic [31:0]   ramRdata;
  logic          respErr;
  logic          unusedAdrLo;

  assign unusedAdrLo = ^i_wb_adr[1:0];

`ifdef ZAP_WB_SLAVE_ERR_EN
  logic oor_q;
  logic err_q;

  assign respErr = oor_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      oor_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        oor_q <= |i_wb_adr[31:AW+2];
      end
      err_q <= (state_q == ST_RESP) && i_wb_cyc && oor_q;
    end
  end

  assign o_wb_err = err_q;
`else
  logic unusedAdrHi;

  assign unusedAdrHi = ^i_wb_adr[31:AW+2];
  assign respErr     = 1'b0;
  assign o_wb_err    = 1'b0;
`endif

  // Dropping cyc in WAIT or RESP abandons the request without any response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    accept  = 1'b0;
    ramEn   = 1'b0;
    ramWe   = 4'b0000;
    unique case (state_q)
      ST_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          accept  = 1'b1;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!i_wb_cyc) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
        if (i_wb_cyc && !respErr) begin
          ack_d = 1'b1;
          ramEn = 1'b1;
          ramWe = zap_lane_we(wen_q, sel_q);
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      idx_q   <= '0;
      wen_q   <= 1'b0;
      sel_q   <= 4'b0000;
      wdat_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      if (accept) begin
        idx_q  <= i_wb_adr[AW+1:2];
        wen_q  <= i_wb_wen;
        sel_q  <= i_wb_sel;
        wdat_q <= i_wb_dat;
      end
    end
  end

  zap_ram_simple #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (i_clk),
    .en_i    (ramEn),
    .we_i    (ramWe),
    .addr_i  (idx_q),
    .wdata_i (wdat_q),
    .rdata_o (ramRdata)
  );

  // Read data is only presented during a read acknowledge; zero otherwise.
  assign o_wb_dat = (ack_q && !wen_q) ? ramRdata : 32'd0;
  assign o_wb_ack = ack_q;
  assign o_busy   = (state_q == ST_WAIT) || (state_q == ST_RESP);

endmodule

// File: tb/tb_zap_wb_slave_mem.sv
// Randomised self-checking bench for zap_wb_slave_mem against a transaction-timing
// reference model; honours ZAP_WB_SLAVE_ERR_EN for out-of-range expectations.
module tb_zap_wb_slave_mem;

  localparam int DEPTH = 1024;
  localparam int WS    = 1;
  localparam int AW    = $clog2(DEPTH);
`ifdef ZAP_WB_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, wen = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'd0, datIn = 32'd0;
  logic [31:0] datOut;
  logic        ack, err, busy;

  int checks = 0;
  int failures = 0;
  int edgeCnt = 0;
  bit checkEn = 1'b0;

  // Reference state: expected outputs for the current cycle and a word memory.
  bit             expAck, expErr, expBusy;
  logic [31:0]    expDat;
  logic [31:0]    refMem [DEPTH];
  bit             inFlight = 1'b0;
  int             respEdge;
  bit             mWen, mOor;
  logic [3:0]     mSel;
  logic [31:0]    mDat;
  logic [AW-1:0]  mIdx;

  zap_wb_slave_mem #(
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_wb_cyc  (cyc),
    .i_wb_stb  (stb),
    .i_wb_wen  (wen),
    .i_wb_sel  (sel),
    .i_wb_adr  (adr),
    .i_wb_dat  (datIn),
    .o_wb_dat  (datOut),
    .o_wb_ack  (ack),
    .o_wb_err  (err),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A request accepted at edge E answers at edge E+1+WS unless cyc drops before then.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      inFlight = 1'b0;
      expAck = 1'b0; expErr = 1'b0; expBusy = 1'b0; expDat = 32'd0;
    end else begin
      edgeCnt++;
      expAck = 1'b0; expErr = 1'b0; expDat = 32'd0;
      if (inFlight) begin
        if (!cyc) begin
          inFlight = 1'b0;
        end else if (edgeCnt == respEdge) begin
          inFlight = 1'b0;
          if (ERR_EN && mOor) begin
            expErr = 1'b1;
          end else begin
            expAck = 1'b1;
            if (mWen) begin
              for (int b = 0; b < 4; b++)
                if (mSel[b]) refMem[mIdx][8*b +: 8] = mDat[8*b +: 8];
            end else begin
              expDat = refMem[mIdx];
            end
          end
        end
      end else if (cyc && stb) begin
        inFlight = 1'b1;
        respEdge = edgeCnt + 1 + WS;
        mWen = wen; mSel = sel; mDat = datIn;
        mIdx = adr[AW+1:2];
        mOor = |adr[31:AW+2];
      end
      expBusy = inFlight;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && checkEn) begin
      checkOutput("ack", {31'd0, ack}, {31'd0, expAck});
      checkOutput("err", {31'd0, err}, {31'd0, expErr});
      checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
      checkOutput("dat", datOut, expDat);
    end
  end

  task automatic idleBus(input int n);
    cyc = 1'b0; stb = 1'b0; wen = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Drive a request at a negedge and wait for its response; inputs stay asserted.
  task automatic applyStimulus(input bit w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [31:0] rd,
                               output bit gotAck, output bit gotErr, output int lat);
    int startEdge;
    bit done;
    cyc = 1'b1; stb = 1'b1; wen = w; adr = a; datIn = d; sel = s;
    startEdge = edgeCnt;
    done = 1'b0; gotAck = 1'b0; gotErr = 1'b0; rd = 32'd0; lat = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ack || err) begin
        gotAck = ack; gotErr = err; rd = datOut;
        lat = edgeCnt - startEdge - 1;
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL timeout: got no response, expected one for adr %h", a);
    end
  endtask

  initial begin
    logic [31:0] rd, a;
    bit gA, gE;
    int lat, k, idx;
    int ackEdges [3];
    int unsigned hi;

    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd, a;
    bit gA, gE;
    int lat, k, idx;
    int ackEdges [3];
    int unsigned hi;

    repeat (3) @(negedge clk);
    checkOutput("rstAck", {31'd0, ack}, 32'd0);
    checkOutput("rstErr", {31'd0, err}, 32'd0);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstDat", datOut, 32'd0);
    rst_n = 1'b1;
    checkEn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 32'(i * 4), $urandom, 4'hF, rd, gA, gE, lat);
    idleBus(1);

    applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, rd, gA, gE, lat);
    checkOutput("wrAck", {31'd0, gA}, 32'd1);
    checkOutput("wrLatency", 32'(lat), 32'(1 + WS));
    idleBus(1);
    applyStimulus(1'b0, 32'h0000_0010, 32'd0, 4'hF, rd, gA, gE, lat);
    checkOutput("rdFull", rd, 32'hDEAD_BEEF);
    idleBus(1);

    applyStimulus(1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0101, rd, gA, gE, lat);
    idleBus(1);
    applyStimulus(1'b0, 32'h0000_0010, 32'd0, 4'hF, rd, gA, gE, lat);
    checkOutput("rdLanes", rd, 32'hDE22_BE44);
    applyStimulus(1'b1, 32'h0000_0000, 32'h0000_1111, 4'hF, rd, gA, gE, lat);
    applyStimulus(1'b1, 32'h0000_0004, 32'h2222_0000, 4'hF, rd, gA, gE, lat);
    applyStimulus(1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'b0000, rd, gA, gE, lat);
    checkOutput("sel0Ack", {31'd0, gA}, 32'd1);
    idleBus(1);

    applyStimulus(1'b0, 32'h0000_0010, 32'd0, 4'hF, rd, gA, gE, lat);
    ackEdges[0] = edgeCnt;
    checkOutput("b2b0", rd, 32'hDE22_BE44);
    applyStimulus(1'b0, 32'h0000_0000, 32'd0, 4'hF, rd, gA, gE, lat);
    ackEdges[1] = edgeCnt;
    checkOutput("b2b1", rd, 32'h0000_1111);
    applyStimulus(1'b0, 32'h0000_0004, 32'd0, 4'hF, rd, gA, gE, lat);
    ackEdges[2] = edgeCnt;
    checkOutput("b2b2", rd, 32'h2222_0000);
    checkOutput("b2bGap1", 32'(ackEdges[1] - ackEdges[0]), 32'(WS + 2));
    checkOutput("b2bGap2", 32'(ackEdges[2] - ackEdges[1]), 32'(WS + 2));
    idleBus(3);

    cyc = 1'b1; stb = 1'b1; wen = 1'b1; adr = 32'h10; datIn = 32'hFFFF_FFFF; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    checkOutput("abortAck", {31'd0, ack}, 32'd0);
    idleBus(1);
    applyStimulus(1'b0, 32'h0000_0010, 32'd0, 4'hF, rd, gA, gE, lat);
    checkOutput("abortMem", rd, 32'hDE22_BE44);
    idleBus(1);

    applyStimulus(1'b0, 32'h0000_1000, 32'd0, 4'hF, rd, gA, gE, lat);
    if (ERR_EN) begin
      checkOutput("oorErr", {31'd0, gE}, 32'd1);
      checkOutput("oorNoAck", {31'd0, gA}, 32'd0);
      checkOutput("oorDat", rd, 32'd0);
    end else begin
      checkOutput("wrapAck", {31'd0, gA}, 32'd1);
      checkOutput("wrapDat", rd, 32'h0000_1111);
    end
    idleBus(1);

    cyc = 1'b1; stb = 1'b1; wen = 1'b0; adr = 32'h4; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncAck", {31'd0, ack}, 32'd0);
    checkOutput("asyncErr", {31'd0, err}, 32'd0);
    checkOutput("asyncBusy", {31'd0, busy}, 32'd0);
    checkOutput("asyncDat", datOut, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0000_0004, 32'd0, 4'hF, rd, gA, gE, lat);
    checkOutput("postRst", rd, 32'h2222_0000);
    idleBus(1);

    for (int n = 0; n < 300; n++) begin
      idx = $urandom_range(0, 15);
      a = 32'(idx) << 2;
      a = a | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        hi = $urandom_range(1, (1 << (32 - AW - 2)) - 1);
        a = a | (32'(hi) << (AW + 2));
      end
      if ($urandom_range(0, 9) == 0) begin
        cyc = 1'b1; stb = 1'b1; wen = 1'($urandom_range(0, 1));
        adr = a; datIn = $urandom; sel = 4'($urandom_range(0, 15));
        k = $urandom_range(0, WS);
        @(posedge clk);
        repeat (k) @(posedge clk);
        @(negedge clk);
        idleBus(1);
      end else begin
        applyStimulus(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                      rd, gA, gE, lat);
        if ($urandom_range(0, 2) == 0) idleBus($urandom_range(1, 2));
      end
    end
    idleBus(4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
